// File: rtl/debounce_event.sv
// Button debouncer with press/release pulses and hold-to-repeat.
// The release pulse port is named rel because "release" is a reserved word.
module debounce_event #(
    parameter int unsigned DEB_CYCLES    = 4,
    parameter int unsigned HOLD_CYCLES   = 10,
    parameter int unsigned REPEAT_CYCLES = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic sig1,
    output logic level,
    output logic press,
    output logic rel,
    output logic rpt
);

    localparam int unsigned DW   = $clog2(DEB_CYCLES + 1);
    localparam int unsigned TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    localparam logic [DW-1:0] DebLast = DW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] HoldLim = TW'(HOLD_CYCLES);
    localparam logic [TW-1:0] RepLim  = TW'(REPEAT_CYCLES);
    localparam logic [TW-1:0] TOne    = TW'(1);

    typedef enum logic [1:0] {StIdle, StHold, StRepeat} state_e;

    state_e        state;
    logic [DW-1:0] deb_cnt;
    logic [TW-1:0] tcnt;
    logic          mismatch;
    logic          qualify;
    logic          rise;
    logic          fall;

    // A level change happens on the DEB_CYCLES-th consecutive mismatching sample.
    assign mismatch = (sig1 != level);
    assign qualify  = mismatch && (deb_cnt == DebLast);
    assign rise     = qualify && !level;
    assign fall     = qualify && level;

    // Debounce counter, debounced level and the registered press/release pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level   <= 1'b0;
            deb_cnt <= '0;
            press   <= 1'b0;
            rel     <= 1'b0;
        end else begin
            press <= rise;
            rel   <= fall;
            if (!mismatch) begin
                deb_cnt <= '0;
            end else if (qualify) begin
                level   <= sig1;
                deb_cnt <= '0;
            end else begin
                // Only reached while deb_cnt < DebLast, so it can never wrap.
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    // Hold / auto-repeat sequencer; a level fall on the same edge always wins over an rpt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= StIdle;
            tcnt  <= '0;
            rpt   <= 1'b0;
        end else begin
            rpt <= 1'b0;
            case (state)
                StIdle: begin
                    if (rise) begin
                        state <= StHold;
                        tcnt  <= TOne;
                    end
                end
                StHold: begin
                    if (fall) begin
                        state <= StIdle;
                        tcnt  <= '0;
                    end else if (tcnt >= HoldLim) begin
                        rpt   <= 1'b1;
                        tcnt  <= TOne;
                        state <= StRepeat;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                StRepeat: begin
                    if (fall) begin
                        state <= StIdle;
                        tcnt  <= '0;
                    end else if (tcnt >= RepLim) begin
                        rpt  <= 1'b1;
                        tcnt <= TOne;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: begin
                    state <= StIdle;
                    tcnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debounce_event.sv
// Scoreboard bench for debounce_event: a window/elapsed-time reference model queues the
// expected outputs for every clock edge; an independent monitor pops and compares.
module tb_debounce_event;

    localparam int unsigned DEB  = 4;
    localparam int unsigned HOLD = 10;
    localparam int unsigned REP  = 5;

    logic clk;
    logic rst;
    logic sig1;
    logic level;
    logic press;
    logic rel;
    logic rpt;

    debounce_event #(
        .DEB_CYCLES   (DEB),
        .HOLD_CYCLES  (HOLD),
        .REPEAT_CYCLES(REP)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .sig1 (sig1),
        .level(level),
        .press(press),
        .rel  (rel),
        .rpt  (rpt)
    );

    typedef struct packed {
        logic level;
        logic press;
        logic rel;
        logic rpt;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: level flips when the last DEB samples since the previous flip all
    // differ from it; rpt is derived from the number of edges elapsed since the press.
    bit   m_lvl;
    bit   m_win[$];
    int   m_t;
    int   m_press_t;
    int   m_d;
    bit   m_chg;
    obs_t m_e;

    always @(posedge clk) begin
        m_e = '0;
        if (rst) begin
            m_lvl     = 1'b0;
            m_win.delete();
            m_t       = 0;
            m_press_t = 0;
        end else begin
            m_win.push_back(sig1);
            if (m_win.size() > int'(DEB)) void'(m_win.pop_front());
            m_chg = (m_win.size() == int'(DEB));
            foreach (m_win[i]) if (m_win[i] == m_lvl) m_chg = 1'b0;
            if (m_chg) begin
                m_e.press = !m_lvl;
                m_e.rel   = m_lvl;
                if (!m_lvl) m_press_t = m_t;
                m_lvl = !m_lvl;
                m_win.delete();
            end else if (m_lvl) begin
                m_d = m_t - m_press_t;
                m_e.rpt = (m_d == int'(HOLD)) ||
                          (m_d > int'(HOLD) && ((m_d - int'(HOLD)) % int'(REP)) == 0);
            end
            m_e.level = m_lvl;
            m_t++;
        end
        exp_q.push_back(m_e);
    end

    // Monitor: one observation per edge, sampled 1 time unit after the edge.
    obs_t mon_exp;
    obs_t mon_act;

    always @(posedge clk) begin
        #1;
        mon_act = {level, press, rel, rpt};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty t=%0t got %b with nothing expected", $time, mon_act);
        end else begin
            mon_exp = exp_q.pop_front();
            if (mon_act !== mon_exp) begin
                errors++;
                $display("FAIL outputs t=%0t level/press/rel/rpt got %b expected %b",
                         $time, mon_act, mon_exp);
            end
        end
        checks++;
        if ($countones({press, rel, rpt}) > 1) begin
            errors++;
            $display("FAIL exclusive t=%0t press/rel/rpt got %b expected at most one high",
                     $time, {press, rel, rpt});
        end
    end

    task automatic drive(input bit v, input int n);
        repeat (n) begin
            @(negedge clk);
            sig1 = v;
        end
    endtask

    task automatic chk_zero(input string name);
        checks++;
        if ({level, press, rel, rpt} !== 4'b0000) begin
            errors++;
            $display("FAIL %s t=%0t got %b expected 0000", name, $time,
                     {level, press, rel, rpt});
        end
    endtask

    initial begin
        rst  = 1'b0;
        sig1 = 1'b0;
        #1 rst = 1'b1;
        #2 chk_zero("reset_before_clock");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        drive(0, 3);

        // Glitch rejection: 1,1,1,0,1,1,1 never qualifies.
        drive(1, 3);
        drive(0, 1);
        drive(1, 3);
        drive(0, 6);

        // Long hold: press, then rpt at +10, +15, +20, ...
        drive(1, 4 + 40);
        drive(0, 8);

        // Release qualifying at press+12.
        drive(1, 12);
        drive(0, 8);

        // Release qualifying at press+10, the edge of the first scheduled rpt.
        drive(1, 10);
        drive(0, 8);

        // Reset at press+7 with sig1 held high, then requalify after deassertion.
        drive(1, 11);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk_zero("reset_mid_hold");
        repeat (2) @(negedge clk);
        chk_zero("reset_held");
        rst = 1'b0;
        drive(1, 10);
        drive(0, 8);

        // Randomized runs, including short bounces and occasional asynchronous resets.
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                @(negedge clk);
                #1 rst = 1'b1;
                #1 chk_zero("reset_random");
                @(negedge clk);
                rst = 1'b0;
            end
            drive(1'($urandom_range(0, 1)), int'($urandom_range(1, 30)));
        end

        drive(0, 10);
        repeat (2) @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/debounce_event.md
DEBOUNCE_EVENT -- requirements
Module: debounce_event

Interface
REQ-001 Parameter: DEB_CYCLES, default 4, consecutive mismatching samples needed to change the debounced level; legal range 1..65535.
REQ-002 Parameter: HOLD_CYCLES, default 10, cycles the debounced level must stay high after a press before the first repeat; legal range 1..2^24-1.
REQ-003 Parameter: REPEAT_CYCLES, default 5, period of auto-repeat pulses after the first repeat; legal range 1..2^24-1.
REQ-004 Port: clk  input  1  single rising-edge system clock; all state in this domain.
REQ-005 Port: rst  input  1  asynchronous, active-high reset.
REQ-006 Port: sig1  input  1  button level already synchronized to clk by the upstream two-flop synchronizer; may still bounce.
REQ-007 Port: level  output  1  debounced button level.
REQ-008 Port: press  output  1  one-cycle pulse on debounced 0->1.
REQ-009 Port: release  output  1  one-cycle pulse on debounced 1->0.
REQ-010 Port: rpt  output  1  one-cycle auto-repeat pulse while held.

Function
REQ-011 Debounce counter width SHALL be ceil(log2(DEB_CYCLES+1)); hold/repeat counter width SHALL be ceil(log2(max(HOLD_CYCLES,REPEAT_CYCLES)+1)); counters SHALL saturate and never wrap.
REQ-012 Each edge: sig1==level -> debounce counter cleared to 0.
REQ-013 Each edge: sig1!=level and counter < DEB_CYCLES-1 -> counter increments.
REQ-014 Each edge: sig1!=level and counter == DEB_CYCLES-1 -> level takes sig1, counter cleared; i.e. level changes on the DEB_CYCLES-th consecutive mismatching edge.
REQ-015 A single matching sample before the count completes SHALL restart qualification from 0 (glitch rejection).
REQ-016 press SHALL be registered high on the same edge that level goes 0->1 and low on the next edge; release likewise for 1->0.
REQ-017 State machine, states IDLE, HOLD, REPEAT; encoding free.
REQ-018 IDLE: on the edge level goes 1 -> HOLD, hold counter loaded to 1.
REQ-019 HOLD: counter increments each edge; on the edge the counter would exceed HOLD_CYCLES-1, i.e. HOLD_CYCLES edges after press, rpt pulses one cycle, counter cleared to 1, -> REPEAT.
REQ-020 REPEAT: counter increments; every REPEAT_CYCLES edges rpt pulses one cycle and counter reloads to 1.
REQ-021 HOLD or REPEAT: on the edge level goes 0 -> IDLE, counter cleared; release and rpt SHALL never be high in the same cycle (release wins, rpt suppressed).
REQ-022 press, release, rpt SHALL be mutually exclusive and each at most one cycle wide; no rpt SHALL ever occur in IDLE.
REQ-023 A sig1 change qualifying simultaneously with a hold/repeat expiry SHALL take the level-change action only.
REQ-024 With DEB_CYCLES==1, level SHALL follow sig1 with one edge of latency and pulses SHALL still be single-cycle.

Reset
REQ-025 While rst is high: level=0, press=0, release=0, rpt=0, state IDLE, all counters 0, independent of clk.
REQ-026 Reset mid-press SHALL discard all history; after rst falls a held-high sig1 SHALL requalify over DEB_CYCLES edges and produce a fresh press.
REQ-027 Deassertion SHALL be usable asynchronously; no output pulse SHALL be generated by reset assertion or deassertion itself.

Verification (DEB=4, HOLD=10, REPEAT=5)
REQ-028 sig1 0->1 held -> level and press high at 4th edge sampling 1; press low next cycle.
REQ-029 sig1 pattern 1,1,1,0,1,1,1 from level 0 -> no level change, no press (counter reset by the 0).
REQ-030 Hold sig1 high 40 cycles after press -> rpt at press+10, then +15, +20, +25, ...; each one cycle.
REQ-031 Release at press+12 (qualified after 4 low samples) -> release pulse, return to IDLE, no further rpt.
REQ-032 Assert rst at press+7, release it with sig1 still high -> all outputs 0 during reset, new press 4 edges after deassertion.
REQ-033 Release qualifying on same edge as a scheduled rpt -> release=1, rpt=0.
